// File: rtl/counter_unit_pkg.sv
// Shared definitions for the counter_unit block: width, state encoding,
// direction/mode encodings and the wrap-detect helper.
package counter_unit_pkg;

  // The downstream mux consumes exactly 8 bits; no other width is supported.
  localparam int CNT_WIDTH = 8;

  typedef logic [CNT_WIDTH-1:0] cnt_value_t;

  typedef enum logic {
    CNT_STATE_COUNT = 1'b0,
    CNT_STATE_HALT  = 1'b1
  } cnt_state_e;

  localparam logic CNT_DIR_UP       = 1'b1;
  localparam logic CNT_DIR_DOWN     = 1'b0;
  localparam logic CNT_MODE_WRAP    = 1'b0;
  localparam logic CNT_MODE_ONESHOT = 1'b1;

  localparam cnt_value_t CNT_MAX = '1;
  localparam cnt_value_t CNT_MIN = '0;

  // A step wraps when leaving the top value upwards or the bottom value downwards.
  function automatic logic cnt_is_wrap(input cnt_value_t value, input logic up_down);
    return (up_down == CNT_DIR_UP) ? (value == CNT_MAX) : (value == CNT_MIN);
  endfunction

endpackage

// File: rtl/counter_unit_if.sv
// Control/status bundle between the counter's controller (master) and the
// counter itself (slave). Clock and reset are carried as plain ports.
interface counter_unit_if;
  import counter_unit_pkg::*;

  logic       load;
  cnt_value_t load_value;
  logic       enable;
  logic       up_down;
  logic       mode;
  logic       clear_carry;
  cnt_value_t counter_value;
  logic       counter_carry;
  logic       tc_pulse;
  logic       running;

  modport master (
    output load, load_value, enable, up_down, mode, clear_carry,
    input  counter_value, counter_carry, tc_pulse, running
  );

  modport slave (
    input  load, load_value, enable, up_down, mode, clear_carry,
    output counter_value, counter_carry, tc_pulse, running
  );

endinterface

// File: rtl/counter_unit.sv
// Loadable 8-bit up/down counter feeding the output mux value and carry
// inputs. Free-running wrap or one-shot halt at the terminal count, with a
// sticky carry flag and a one-cycle terminal-count strobe.
module counter_unit
  import counter_unit_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  counter_unit_if.slave  bus
);

  cnt_state_e state_q, state_d;
  cnt_value_t value_q, value_d;
  logic       carry_q, carry_d;
  logic       tc_pulse_q, tc_pulse_d;

  logic step;
  logic wrap;

  // Next-state, next-value and wrap detection; load outranks a count step.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned and infers a latch.
    state_d    = state_q;
    value_d    = value_q;
    carry_d    = carry_q;
    tc_pulse_d = 1'b0;

    step = (state_q == CNT_STATE_COUNT) && bus.enable && !bus.load;
    wrap = step && cnt_is_wrap(value_q, bus.up_down);

    // Clear is applied first so a same-cycle wrap below overrides it.
    if (bus.clear_carry) begin
      carry_d = 1'b0;
    end

    if (bus.load) begin
      value_d = bus.load_value;
      carry_d = 1'b0;
      state_d = CNT_STATE_COUNT;
    end else if (step) begin
      if (wrap) begin
        carry_d    = 1'b1;
        tc_pulse_d = 1'b1;
      end
      if (wrap && (bus.mode == CNT_MODE_ONESHOT)) begin
        // Hold at the terminal value; only load or reset leaves HALT.
        state_d = CNT_STATE_HALT;
      end else if (bus.up_down == CNT_DIR_UP) begin
        value_d = value_q + 1'b1;
      end else begin
        value_d = value_q - 1'b1;
      end
    end
  end

  // State, value, carry and strobe registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    if (reset) begin
      state_q    <= CNT_STATE_COUNT;
      value_q    <= '0;
      carry_q    <= 1'b0;
      tc_pulse_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      carry_q    <= carry_d;
      tc_pulse_q <= tc_pulse_d;
    end
  end

  assign bus.counter_value = value_q;
  assign bus.counter_carry = carry_q;
  assign bus.tc_pulse      = tc_pulse_q;
  assign bus.running       = (state_q == CNT_STATE_COUNT);

endmodule

// File: tb/tb_counter_unit.sv
// Directed bench for counter_unit: reset priority, wrap and one-shot
// counting, carry set/clear precedence, load-over-enable, full 256-step loop.
module tb_counter_unit;
  import counter_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   tc_count;

  counter_unit_if bus ();

  counter_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] val, input logic carry,
                            input logic tc, input logic run);
    check({tag, ".value"}, 32'(bus.counter_value), 32'(val));
    check({tag, ".carry"}, 32'(bus.counter_carry), 32'(carry));
    check({tag, ".tc"},    32'(bus.tc_pulse),      32'(tc));
    check({tag, ".run"},   32'(bus.running),       32'(run));
  endtask

  initial begin
    reset           = 1'b1;
    bus.load        = 1'b1;
    bus.load_value  = 8'h55;
    bus.enable      = 1'b1;
    bus.up_down     = 1'b1;
    bus.mode        = 1'b0;
    bus.clear_carry = 1'b0;
    @(negedge clk);

    // Reset outranks a same-cycle load.
    tick();
    expect_out("reset", 8'h00, 1'b0, 1'b0, 1'b1);
    reset      = 1'b0;
    bus.enable = 1'b0;

    // Free-running up count across the wrap.
    bus.load_value = 8'hFD;
    tick();
    expect_out("ld_fd", 8'hFD, 1'b0, 1'b0, 1'b1);
    bus.load   = 1'b0;
    bus.enable = 1'b1;
    tick(); expect_out("up1", 8'hFE, 1'b0, 1'b0, 1'b1);
    tick(); expect_out("up2", 8'hFF, 1'b0, 1'b0, 1'b1);
    tick(); expect_out("up3", 8'h00, 1'b1, 1'b1, 1'b1);
    tick(); expect_out("up4", 8'h01, 1'b1, 1'b0, 1'b1);
    bus.enable = 1'b0;
    tick(); expect_out("hold", 8'h01, 1'b1, 1'b0, 1'b1);

    // One-shot down count: the wrap is the step out of 0x00, which holds there.
    bus.load       = 1'b1;
    bus.load_value = 8'h02;
    bus.up_down    = 1'b0;
    bus.mode       = 1'b1;
    tick(); expect_out("ld_02", 8'h02, 1'b0, 1'b0, 1'b1);
    bus.load   = 1'b0;
    bus.enable = 1'b1;
    tick(); expect_out("os1", 8'h01, 1'b0, 1'b0, 1'b1);
    tick(); expect_out("os2", 8'h00, 1'b0, 1'b0, 1'b1);
    tick(); expect_out("os3", 8'h00, 1'b1, 1'b1, 1'b0);
    tick(); expect_out("os4", 8'h00, 1'b1, 1'b0, 1'b0);
    bus.mode = 1'b0;
    tick(); expect_out("os_halt_mode0", 8'h00, 1'b1, 1'b0, 1'b0);
    bus.load       = 1'b1;
    bus.load_value = 8'h10;
    tick(); expect_out("ld_10", 8'h10, 1'b0, 1'b0, 1'b1);

    // Wrap and clear_carry together: set wins; clear alone then clears.
    bus.load_value = 8'hFF;
    bus.up_down    = 1'b1;
    bus.mode       = 1'b0;
    bus.enable     = 1'b0;
    tick(); expect_out("ld_ff", 8'hFF, 1'b0, 1'b0, 1'b1);
    bus.load        = 1'b0;
    bus.enable      = 1'b1;
    bus.clear_carry = 1'b1;
    tick(); expect_out("set_wins", 8'h00, 1'b1, 1'b1, 1'b1);
    bus.enable = 1'b0;
    tick(); expect_out("clear", 8'h00, 1'b0, 1'b0, 1'b1);
    bus.clear_carry = 1'b0;

    // Load with enable: load captured, no extra step.
    bus.load       = 1'b1;
    bus.load_value = 8'hA0;
    bus.enable     = 1'b1;
    tick(); expect_out("ld_en", 8'hA0, 1'b0, 1'b0, 1'b1);

    // Full 256-step free-running loop returns to 0x00 with one strobe.
    bus.load_value = 8'h00;
    tick(); expect_out("ld_00", 8'h00, 1'b0, 1'b0, 1'b1);
    bus.load = 1'b0;
    tc_count = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (bus.tc_pulse === 1'b1) tc_count++;
    end
    expect_out("loop_end", 8'h00, 1'b1, 1'b1, 1'b1);
    check("loop_tc_count", 32'(tc_count), 32'd1);

    // Reset mid-run overrides load, enable and clear_carry.
    for (int i = 0; i < 5; i++) tick();
    check("pre_reset_value", 32'(bus.counter_value), 32'h05);
    reset           = 1'b1;
    bus.load        = 1'b1;
    bus.load_value  = 8'h77;
    bus.clear_carry = 1'b1;
    tick(); expect_out("mid_reset", 8'h00, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
